// File: rtl/eje01_planta.sv
// eje01_planta - single-axis actuator plant model that closes the loop
// around the eje01 controller. It consumes the A/E/P commands and produces
// the sf/sm sensor signals from a position counter.
//
// Parameters:
//   TRAVEL       end-of-travel position, position range is 0..TRAVEL
//   STEP_DIV     clock cycles per position step (>= 1)
//   BRAKE_CYCLES coast cycles after a stop (inertia build only)
//
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   asynchronous active-high reset
//   A      in   command: move forward (toward TRAVEL)
//   E      in   command: move reverse (toward 0)
//   P      in   command: stop/brake, highest priority
//   sf     out  end-of-travel sensor, 1 when pos == TRAVEL
//   sm     out  motion sensor, 1 while the axis is moving
//   pos    out  current position
//   fault  out  sticky fault flag, cleared only by reset
//
// Build option:
//   PLANT_INERTIA_EN  when defined, a stop enters BRAKE and the axis keeps
//                     coasting for BRAKE_CYCLES cycles before going idle.
//
// All outputs decode from registers only; there is no combinational path
// from the command inputs to any output.

module eje01_planta #(
    parameter int TRAVEL       = 8,
    parameter int STEP_DIV     = 2,
    parameter int BRAKE_CYCLES = 3,
    localparam int POS_W       = $clog2(TRAVEL + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             A,
    input  logic             E,
    input  logic             P,
    output logic             sf,
    output logic             sm,
    output logic [POS_W-1:0] pos,
    output logic             fault
);

    localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    // Elaboration-time guard against parameter values the model cannot honour
    if (TRAVEL < 1 || STEP_DIV < 1 || BRAKE_CYCLES < 1) begin : g_param_check
        $error("eje01_planta: TRAVEL, STEP_DIV and BRAKE_CYCLES must all be >= 1");
    end

`ifdef PLANT_INERTIA_EN
    localparam int BRK_W = (BRAKE_CYCLES > 1) ? $clog2(BRAKE_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, MOVE_FWD, MOVE_REV, FAULT, BRAKE} state_t;
    localparam state_t STOP_STATE = BRAKE;
`else
    typedef enum logic [2:0] {IDLE, MOVE_FWD, MOVE_REV, FAULT} state_t;
    localparam state_t STOP_STATE = IDLE;
`endif

    state_t           state, state_next;
    logic [POS_W-1:0] pos_next;
    logic [DIV_W-1:0] div, div_next;
    logic             div_last;

`ifdef PLANT_INERTIA_EN
    logic [BRK_W-1:0] brk_cnt, brk_next;
    logic             dir_fwd, dir_next;
`endif

    assign div_last = (div == DIV_W'(STEP_DIV - 1));

    // Sensors decode purely from the state and position registers
    assign sf    = (pos == POS_W'(TRAVEL));
    assign fault = (state == FAULT);
`ifdef PLANT_INERTIA_EN
    assign sm    = (state == MOVE_FWD) || (state == MOVE_REV) || (state == BRAKE);
`else
    assign sm    = (state == MOVE_FWD) || (state == MOVE_REV);
`endif

    // State, position and divider registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            pos     <= '0;
            div     <= '0;
`ifdef PLANT_INERTIA_EN
            brk_cnt <= '0;
            dir_fwd <= 1'b0;
`endif
        end else begin
            state   <= state_next;
            pos     <= pos_next;
            div     <= div_next;
`ifdef PLANT_INERTIA_EN
            brk_cnt <= brk_next;
            dir_fwd <= dir_next;
`endif
        end
    end

    // Next-state logic. Inside a move, P wins, then the opposite command
    // (which faults even when the active command is still held), then a
    // dropped active command; only a clean hold of the active command steps.
    always_comb begin
        state_next = state;
        pos_next   = pos;
        div_next   = div;
`ifdef PLANT_INERTIA_EN
        brk_next   = '0;
        dir_next   = dir_fwd;
`endif
        case (state)
            IDLE: begin
                div_next = '0;
                if (P) begin
                    state_next = IDLE;
                end else if (A && E) begin
                    state_next = FAULT;
                end else if (A && (pos != POS_W'(TRAVEL))) begin
                    state_next = MOVE_FWD;
`ifdef PLANT_INERTIA_EN
                    dir_next   = 1'b1;
`endif
                end else if (E && (pos != '0)) begin
                    state_next = MOVE_REV;
`ifdef PLANT_INERTIA_EN
                    dir_next   = 1'b0;
`endif
                end
            end

            MOVE_FWD: begin
                if (P || (!E && !A)) begin
                    state_next = STOP_STATE;
                    div_next   = '0;
                end else if (E) begin
                    state_next = FAULT;
                end else if (div_last) begin
                    pos_next = pos + 1'b1;
                    div_next = '0;
                    if (pos == POS_W'(TRAVEL - 1))
                        state_next = IDLE;
                end else begin
                    div_next = div + 1'b1;
                end
            end

            MOVE_REV: begin
                if (P || (!A && !E)) begin
                    state_next = STOP_STATE;
                    div_next   = '0;
                end else if (A) begin
                    state_next = FAULT;
                end else if (div_last) begin
                    pos_next = pos - 1'b1;
                    div_next = '0;
                    if (pos == POS_W'(1))
                        state_next = IDLE;
                end else begin
                    div_next = div + 1'b1;
                end
            end

`ifdef PLANT_INERTIA_EN
            // Coast in the stored direction, ignoring commands, until the
            // brake window expires or the endpoint is reached
            BRAKE: begin
                brk_next = brk_cnt + 1'b1;
                if (div_last) begin
                    div_next = '0;
                    if (dir_fwd && (pos != POS_W'(TRAVEL))) begin
                        pos_next = pos + 1'b1;
                        if (pos == POS_W'(TRAVEL - 1))
                            state_next = IDLE;
                    end else if (!dir_fwd && (pos != '0)) begin
                        pos_next = pos - 1'b1;
                        if (pos == POS_W'(1))
                            state_next = IDLE;
                    end
                end else begin
                    div_next = div + 1'b1;
                end
                if (brk_cnt == BRK_W'(BRAKE_CYCLES - 1)) begin
                    state_next = IDLE;
                    brk_next   = '0;
                end
            end
`endif

            FAULT: begin
                state_next = FAULT;
            end

            default: begin
                state_next = FAULT;
            end
        endcase
    end

endmodule

// File: tb/tb_eje01_planta.sv
// tb_eje01_planta - directed testbench for eje01_planta with default
// parameters (TRAVEL = 8, STEP_DIV = 2, BRAKE_CYCLES = 3). Expected values
// are hand-computed from the plant behaviour.

module tb_eje01_planta;

    logic       clk = 1'b0;
    logic       reset;
    logic       A, E, P;
    logic       sf, sm, fault;
    logic [3:0] pos;

    int checks = 0;
    int errors = 0;
    int stop_pos;

    eje01_planta dut (
        .clk   (clk),
        .reset (reset),
        .A     (A),
        .E     (E),
        .P     (P),
        .sf    (sf),
        .sm    (sm),
        .pos   (pos),
        .fault (fault)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic checkAll(input string tag, input int exp_pos, input int exp_sf,
                            input int exp_sm, input int exp_fault);
        checkOutput({tag, ".pos"},   int'(pos),   exp_pos);
        checkOutput({tag, ".sf"},    int'(sf),    exp_sf);
        checkOutput({tag, ".sm"},    int'(sm),    exp_sm);
        checkOutput({tag, ".fault"}, int'(fault), exp_fault);
    endtask

    task automatic applyStimulus(input logic a, input logic e, input logic p);
        A = a;
        E = e;
        P = p;
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Guard against a hung simulation
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset held for two cycles, then quiet idle
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick();
        tick();
        checkAll("reset", 0, 0, 0, 0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checkAll($sformatf("idle%0d", i), 0, 0, 0, 0);
        end

        // Forward travel from 0: one step every two edges, stop at TRAVEL
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick();
        checkAll("fwd_start", 0, 0, 1, 0);
        for (int j = 1; j <= 16; j++) begin
            tick();
            checkAll($sformatf("fwd_e%0d", j), j / 2, (j == 16) ? 1 : 0,
                     (j < 16) ? 1 : 0, 0);
        end
        tick();
        checkAll("fwd_top_hold", 8, 1, 0, 0);

        // Reverse travel from TRAVEL back to 0
        applyStimulus(1'b0, 1'b1, 1'b0);
        tick();
        checkAll("rev_start", 8, 1, 1, 0);
        for (int j = 1; j <= 16; j++) begin
            tick();
            checkAll($sformatf("rev_e%0d", j), 8 - j / 2, (j < 2) ? 1 : 0,
                     (j < 16) ? 1 : 0, 0);
        end
        tick();
        checkAll("rev_bot_hold", 0, 0, 0, 0);

        // Stop pulse during forward move at pos 3
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 6; i++) tick();
        checkAll("pre_stop", 3, 0, 1, 0);
        applyStimulus(1'b1, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
`ifdef PLANT_INERTIA_EN
        checkAll("brake1", 3, 0, 1, 0);
        tick();
        checkAll("brake2", 3, 0, 1, 0);
        tick();
        checkAll("brake3", 4, 0, 1, 0);
        tick();
        checkAll("brake_done", 4, 0, 0, 0);
        stop_pos = 4;
`else
        checkAll("stop", 3, 0, 0, 0);
        tick();
        checkAll("stop_hold", 3, 0, 0, 0);
        stop_pos = 3;
`endif

        // Conflicting commands in idle fault the plant; fault is sticky
        applyStimulus(1'b1, 1'b1, 1'b0);
        tick();
        checkAll("conflict", stop_pos, 0, 0, 1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick();
        tick();
        checkAll("fault_sticky", stop_pos, 0, 0, 1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1 checkAll("fault_reset", 0, 0, 0, 0);
        tick();
        reset = 1'b0;

        // Opposite command during a forward move faults, with no step taken
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick();
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0);
        tick();
        checkAll("reverse_fault", 0, 0, 0, 1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // Reset mid-step clears position before the next edge
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        checkAll("mid_step_pre", 1, 0, 1, 0);
        tick();
        #2 reset = 1'b1;
        #1 checkAll("async_reset", 0, 0, 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        tick();
        checkAll("post_reset", 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
